fetch_pc_unit: RTL and testbench

Fetch-stage program-counter unit consuming the decode-stage redirect decision (3-bit branch select, nullify, delay-slot marking) and producing the fetch address each cycle. Holds the PC register, buffers a redirect that arrives while fetch is stalled, and generates the registered delay-slot flag and IF/ID kill for the decode stage. Sits between the decode-stage branch controller and the instruction memory / IF-ID pipeline register.

---
 rtl/fetch_pc_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Fetch-stage program counter. It takes the redirect decided in decode and
//   produces the fetch address each cycle. A redirect that arrives while fetch
//   is stalled is held until the stall is released. The unit also registers
//   the delay-slot flag and the IF/ID kill that decode sees.
//
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   stall_f             hold PC and IF/ID this cycle
//   branch_select[2:0]  0 seq, 1 branch, 2 j/jal, 3 jr/jalr, 4 eret, 5-7 = seq
//   branch_target       PC-relative target
//   jump_target         absolute j/jal target
//   jr_target           register target
//   epc                 CP0 EPC, used by eret
//   nullify             branch-likely not taken: annul the slot now in fetch
//   exc_req             exception commit; overrides everything, even a stall
//   pc_f, pc_plus4_f    fetch address and fetch address + 4
//   slot_d              instruction entering decode is a delay slot
//   kill_d              instruction entering decode is a bubble
//   pending_o           a buffered redirect is waiting for the stall to end
//   adel_f              fetch address is misaligned
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_f,
  input  logic [2:0]  branch_select,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic [31:0] epc,
  input  logic        nullify,
  input  logic        exc_req,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        slot_d,
  output logic        kill_d,
  output logic        pending_o,
  output logic        adel_f
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ptgt_q, ptgt_d;
  logic        pslot_q, pslot_d;
  logic        pkill_q, pkill_d;
  logic        dslot_q, dslot_d;
  logic        dkill_q, dkill_d;

  logic        redirect;
  logic [31:0] sel_t;
  logic        acc_slot;
  logic        acc_kill;

  // Decode the redirect. Selects 5-7 behave exactly like sequential fetch.
  always_comb begin
    redirect = 1'b1;
    sel_t    = 32'h0;
    case (branch_select)
      3'd1:    sel_t = branch_target;
      3'd2:    sel_t = jump_target;
      3'd3:    sel_t = jr_target;
      3'd4:    sel_t = epc;
      default: redirect = 1'b0;
    endcase
    // eret has no delay slot. It kills the instruction that was fetched
    // behind it.
    acc_slot = redirect && (branch_select != 3'd4);
    acc_kill = nullify || (branch_select == 3'd4);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ptgt_d  = ptgt_q;
    pslot_d = pslot_q;
    pkill_d = pkill_q;
    dslot_d = dslot_q;
    dkill_d = dkill_q;
    if (exc_req) begin
      state_d = RUN;
      pc_d    = EXC_VECTOR;
      ptgt_d  = 32'h0;
      pslot_d = 1'b0;
      pkill_d = 1'b0;
      dslot_d = 1'b0;
      dkill_d = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (stall_f) begin
            // Buffer the redirect. The decode flags are computed now, while
            // the select and nullify inputs are still valid.
            if (redirect) begin
              state_d = HOLD;
              ptgt_d  = sel_t;
              pslot_d = acc_slot;
              pkill_d = acc_kill;
            end
          end else begin
            pc_d    = redirect ? sel_t : pc_q + 32'd4;
            dslot_d = acc_slot;
            dkill_d = acc_kill;
          end
        end
        HOLD: begin
          // The first buffered redirect wins. New selects are ignored until
          // it has been released.
          if (!stall_f) begin
            state_d = RUN;
            pc_d    = ptgt_q;
            ptgt_d  = 32'h0;
            dslot_d = pslot_q;
            dkill_d = pkill_q;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ptgt_q  <= 32'h0;
      pslot_q <= 1'b0;
      pkill_q <= 1'b0;
      dslot_q <= 1'b0;
      dkill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ptgt_q  <= ptgt_d;
      pslot_q <= pslot_d;
      pkill_q <= pkill_d;
      dslot_q <= dslot_d;
      dkill_q <= dkill_d;
    end
  end

  assign pc_f       = pc_q;
  assign pc_plus4_f = pc_q + 32'd4;
  assign slot_d     = dslot_q;
  assign kill_d     = dkill_q;
  assign pending_o  = (state_q == HOLD);
  assign adel_f     = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam logic [31:0] EXV = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_f;
  logic [2:0]  branch_select;
  logic [31:0] branch_target, jump_target, jr_target, epc;
  logic        nullify, exc_req;
  logic [31:0] pc_f, pc_plus4_f;
  logic        slot_d, kill_d, pending_o, adel_f;

  int tests = 0;
  int fails = 0;

  fetch_pc_unit dut (
    .clk(clk), .reset_n(reset_n), .stall_f(stall_f),
    .branch_select(branch_select), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .epc(epc),
    .nullify(nullify), .exc_req(exc_req),
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .slot_d(slot_d), .kill_d(kill_d),
    .pending_o(pending_o), .adel_f(adel_f)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic [2:0]  sel;
    logic        nul;
    logic        exc;
    logic [31:0] tgt;     // applied to whichever target input sel uses
    logic [31:0] e_pc;
    logic        e_slot;
    logic        e_kill;
    logic        e_pend;
  } vec_t;

  localparam int NV = 24;
  vec_t vec [NV];

  function automatic vec_t mk(logic st, logic [2:0] s, logic n, logic x,
                              logic [31:0] t, logic [31:0] p, logic sl,
                              logic k, logic pd);
    vec_t v;
    v.stall = st; v.sel = s; v.nul = n; v.exc = x; v.tgt = t;
    v.e_pc = p; v.e_slot = sl; v.e_kill = k; v.e_pend = pd;
    return v;
  endfunction

  // One comparison of all outputs against the expected values. Each call
  // counts as a single test.
  task automatic check(string name, logic [31:0] p, logic sl, logic k, logic pd);
    logic [31:0] p4;
    logic        ad;
    p4 = p + 32'd4;
    ad = (p[1:0] != 2'b00);
    tests++;
    if (pc_f !== p || pc_plus4_f !== p4 || slot_d !== sl || kill_d !== k ||
        pending_o !== pd || adel_f !== ad) begin
      fails++;
      $display("FAIL %s: got pc=%h p4=%h slot=%b kill=%b pend=%b adel=%b, want pc=%h p4=%h slot=%b kill=%b pend=%b adel=%b",
               name, pc_f, pc_plus4_f, slot_d, kill_d, pending_o, adel_f,
               p, p4, sl, k, pd, ad);
    end
  endtask

  task automatic drive(logic st, logic [2:0] s, logic n, logic x,
                       logic [31:0] bt, logic [31:0] jt, logic [31:0] jr,
                       logic [31:0] ep);
    stall_f = st; branch_select = s; nullify = n; exc_req = x;
    branch_target = bt; jump_target = jt; jr_target = jr; epc = ep;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state.
  logic [31:0] m_pc, m_tgt;
  logic        m_pend, m_pslot, m_pkill, m_slot, m_kill;

  function automatic logic [31:0] rtgt();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(7) != 0) r[1:0] = 2'b00;
    return r;
  endfunction

  initial begin
    // Directed table. The model PC starts at RESET_PC after reset.
    vec[0]  = mk(0, 0, 0, 0, 32'h0,        32'h3004, 0, 0, 0);
    vec[1]  = mk(0, 0, 0, 0, 32'h0,        32'h3008, 0, 0, 0);
    vec[2]  = mk(0, 1, 0, 0, 32'h3100,     32'h3100, 1, 0, 0);
    vec[3]  = mk(0, 0, 0, 0, 32'h0,        32'h3104, 0, 0, 0);
    vec[4]  = mk(1, 3, 0, 0, 32'h3200,     32'h3104, 0, 0, 1);
    vec[5]  = mk(1, 2, 0, 0, 32'h3300,     32'h3104, 0, 0, 1);
    vec[6]  = mk(1, 2, 0, 0, 32'h3300,     32'h3104, 0, 0, 1);
    vec[7]  = mk(0, 2, 0, 0, 32'h3300,     32'h3200, 1, 0, 0);
    vec[8]  = mk(0, 0, 1, 0, 32'h0,        32'h3204, 0, 1, 0);
    vec[9]  = mk(0, 4, 0, 0, 32'h3040,     32'h3040, 0, 1, 0);
    vec[10] = mk(0, 0, 0, 0, 32'h0,        32'h3044, 0, 0, 0);
    vec[11] = mk(1, 1, 0, 0, 32'h3400,     32'h3044, 0, 0, 1);
    vec[12] = mk(1, 0, 0, 1, 32'h0,        EXV,      0, 1, 0);
    vec[13] = mk(0, 0, 0, 0, 32'h0,        32'h4184, 0, 0, 0);
    vec[14] = mk(0, 1, 1, 0, 32'h3500,     32'h3500, 1, 1, 0);
    vec[15] = mk(0, 3, 0, 0, 32'h3202,     32'h3202, 1, 0, 0);
    vec[16] = mk(0, 3, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0);
    vec[17] = mk(0, 0, 0, 0, 32'h0,        32'h0000_0000, 0, 0, 0);
    vec[18] = mk(0, 5, 1, 0, 32'h7777,     32'h0000_0004, 0, 1, 0);
    vec[19] = mk(1, 7, 0, 0, 32'h7777,     32'h0000_0004, 0, 1, 0);
    vec[20] = mk(1, 4, 0, 0, 32'h3600,     32'h0000_0004, 0, 1, 1);
    vec[21] = mk(1, 1, 0, 0, 32'h3700,     32'h0000_0004, 0, 1, 1);
    vec[22] = mk(0, 1, 0, 0, 32'h3700,     32'h3600, 0, 1, 0);
    vec[23] = mk(0, 0, 0, 1, 32'h0,        EXV,      0, 1, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #12;
    check("reset", RPC, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_hold_first_edge", RPC + 32'd4, 0, 0, 0);
    // Reapply reset so that the table starts from RESET_PC.
    reset_n = 1'b0;
    #1;
    check("reset_async", RPC, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].stall, vec[i].sel, vec[i].nul, vec[i].exc,
            vec[i].tgt, vec[i].tgt, vec[i].tgt, vec[i].tgt);
      tick();
      check($sformatf("vec%0d", i), vec[i].e_pc, vec[i].e_slot,
            vec[i].e_kill, vec[i].e_pend);
    end

    // Assert reset in the middle of a cycle while a redirect is buffered.
    drive(1, 1, 0, 0, 32'h5000, 0, 0, 0);
    tick();
    check("pre_reset_pending", EXV, 0, 1, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_cycle_reset", RPC, 0, 0, 0);
    // Release reset while stalled: the PC must stay put.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("reset_release_stalled", RPC, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("first_fetch_after_stall", RPC + 32'd4, 0, 0, 0);

    // Random stimulus compared against the model.
    m_pc = RPC + 32'd4; m_pend = 0; m_tgt = 0; m_pslot = 0; m_pkill = 0;
    m_slot = 0; m_kill = 0;
    for (int c = 0; c < 600; c++) begin
      logic st, n, x, redir;
      logic [2:0] s;
      logic [31:0] bt, jt, jr, ep, t;
      st = ($urandom_range(9) < 3);
      s  = 3'($urandom_range(7));
      n  = ($urandom_range(7) == 0);
      x  = ($urandom_range(19) == 0);
      bt = rtgt(); jt = rtgt(); jr = rtgt(); ep = rtgt();
      if ($urandom_range(15) == 0) begin
        // Periodically steer the PC to the top of memory to cover wrap-around.
        bt = 32'hFFFF_FFF8; jt = 32'hFFFF_FFFC;
      end
      drive(st, s, n, x, bt, jt, jr, ep);

      redir = (s >= 3'd1 && s <= 3'd4);
      t = (s == 3'd1) ? bt : (s == 3'd2) ? jt : (s == 3'd3) ? jr : ep;
      if (x) begin
        m_pc = EXV; m_pend = 0; m_slot = 0; m_kill = 1;
      end else if (m_pend) begin
        if (!st) begin
          m_pc = m_tgt; m_pend = 0; m_slot = m_pslot; m_kill = m_pkill;
        end
      end else if (st) begin
        if (redir) begin
          m_pend = 1; m_tgt = t; m_pslot = (s != 3'd4); m_pkill = n || (s == 3'd4);
        end
      end else begin
        m_pc   = redir ? t : m_pc + 32'd4;
        m_slot = redir && (s != 3'd4);
        m_kill = n || (s == 3'd4);
      end

      tick();
      check($sformatf("rand%0d", c), m_pc, m_slot, m_kill, m_pend);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog against a stalled simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
